qupls_regfile_wrarb: RTL and testbench

Write-port arbiter that produces the four write ports of the 4W/18R physical register file.
- Collects result writebacks from NSRC functional-unit sources, each through a valid/ready handshake.
- Buffers each source in a 2-entry FIFO.
- Each cycle, grants up to four writes in round-robin order and drives registered wr/we/wa/i outputs straight into the register file.
- Guarantees no two ports carry the same physical register in one cycle.

---
 rtl/qupls_regfile_wrarb_pkg.sv | 16 +
 rtl/qupls_regfile_wrarb_fifo.sv | 46 ++++
 rtl/qupls_regfile_wrarb.sv | 182 ++++++++++++++++++
 tb/tb_qupls_regfile_wrarb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/qupls_regfile_wrarb_pkg.sv
// rtl/qupls_regfile_wrarb_pkg.sv - shared types and constants for the register-file write arbiter
package qupls_regfile_wrarb_pkg;

  localparam int PREG_BITS = 9;
  localparam int PREGS     = 2 ** PREG_BITS;
  localparam int NWRPORTS  = 4;

  typedef logic [PREG_BITS-1:0] pregno_t;

  // Physical registers whose low six bits are zero alias architectural r0
  // and are never written.
  function automatic logic is_reg_zero(input logic [5:0] pr_lo);
    return pr_lo == 6'd0;
  endfunction

endpackage

// File: rtl/qupls_regfile_wrarb_fifo.sv
// rtl/qupls_regfile_wrarb_fifo.sv - 2-entry synchronous FIFO buffering one result source
module qupls_wrarb_fifo #(
  parameter int W = 73
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         rp;
  logic         wp;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full    = cnt == 2'd2;
  assign empty   = cnt == 2'd0;
  assign head    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer/count update; flush drops both stored entries and any push on that edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rp  <= 1'b0;
      wp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop)
        rp <= ~rp;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/qupls_regfile_wrarb.sv
// rtl/qupls_regfile_wrarb.sv - round-robin arbiter driving the four register-file write ports (option: QUPLS_WRARB_STATS_EN)
module qupls_regfile_wrarb #(
  parameter int WID  = 64,
  parameter int RBIT = 8,
  parameter int NSRC = 8,
  parameter int NPORT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NSRC-1:0]            src_v,
  output logic [NSRC-1:0]            src_rdy,
  input  logic [NSRC-1:0][RBIT:0]    src_pr,
  input  logic [NSRC-1:0][WID-1:0]   src_dat,
  output logic                       wr0,
  output logic                       wr1,
  output logic                       wr2,
  output logic                       wr3,
  output logic                       we0,
  output logic                       we1,
  output logic                       we2,
  output logic                       we3,
  output logic [RBIT:0]              wa0,
  output logic [RBIT:0]              wa1,
  output logic [RBIT:0]              wa2,
  output logic [RBIT:0]              wa3,
  output logic [WID-1:0]             i0,
  output logic [WID-1:0]             i1,
  output logic [WID-1:0]             i2,
  output logic [WID-1:0]             i3
`ifdef QUPLS_WRARB_STATS_EN
  ,
  output logic [31:0]                stat_writes,
  output logic [31:0]                stat_defers
`endif
);
  import qupls_regfile_wrarb_pkg::*;

  localparam int RRW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int EW  = RBIT + 1 + WID;

  logic [RRW-1:0]   rr;
  logic [NSRC-1:0]  fifo_full;
  logic [NSRC-1:0]  fifo_empty;
  logic [NSRC-1:0]  pop_c;
  logic [EW-1:0]    head [NSRC];
  logic [RBIT:0]    head_pr [NSRC];
  logic [WID-1:0]   head_dat [NSRC];

  logic [RBIT:0]    g_pr [NWRPORTS];
  logic [WID-1:0]   g_dat [NWRPORTS];
  int               g_cnt;
  logic [RRW-1:0]   last_idx;
  logic [RRW-1:0]   rr_next;
`ifdef QUPLS_WRARB_STATS_EN
  int               defers;
`endif

  logic [NWRPORTS-1:0] wr_q;
  logic [RBIT:0]       wa_q [NWRPORTS];
  logic [WID-1:0]      d_q [NWRPORTS];

  assign src_rdy = ~fifo_full;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    qupls_wrarb_fifo #(.W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (src_v[s]),
      .din   ({src_pr[s], src_dat[s]}),
      .pop   (pop_c[s]),
      .full  (fifo_full[s]),
      .empty (fifo_empty[s]),
      .head  (head[s])
    );
    assign head_pr[s]  = head[s][EW-1:WID];
    assign head_dat[s] = head[s][WID-1:0];
  end

  // Scan heads from rr: discard r0 writes, defer address conflicts, grant up to four.
  always_comb begin
    int  idx_i;
    logic [RRW-1:0] idx;
    logic hit;
    pop_c    = '0;
    g_cnt    = 0;
    last_idx = rr;
    idx      = '0;
    hit      = 1'b0;
`ifdef QUPLS_WRARB_STATS_EN
    defers   = 0;
`endif
    for (int p = 0; p < NWRPORTS; p++) begin
      g_pr[p]  = '0;
      g_dat[p] = '0;
    end
    for (int k = 0; k < NSRC; k++) begin
      idx_i = int'(rr) + k;
      if (idx_i >= NSRC)
        idx_i = idx_i - NSRC;
      idx = idx_i[RRW-1:0];
      if (!fifo_empty[idx]) begin
        if (is_reg_zero(head_pr[idx][5:0])) begin
          pop_c[idx] = 1'b1;
        end else if (g_cnt < NWRPORTS) begin
          hit = 1'b0;
          for (int p = 0; p < NWRPORTS; p++)
            if (p < g_cnt && g_pr[p] == head_pr[idx])
              hit = 1'b1;
          if (hit) begin
`ifdef QUPLS_WRARB_STATS_EN
            defers = defers + 1;
`endif
          end else begin
            g_pr[g_cnt[1:0]]  = head_pr[idx];
            g_dat[g_cnt[1:0]] = head_dat[idx];
            pop_c[idx]        = 1'b1;
            last_idx          = idx;
            g_cnt             = g_cnt + 1;
          end
        end
      end
    end
    rr_next = (last_idx == RRW'(NSRC - 1)) ? '0 : last_idx + 1'b1;
  end

  // Register the grants onto the ports and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr   <= '0;
      wr_q <= '0;
      for (int p = 0; p < NWRPORTS; p++) begin
        wa_q[p] <= '0;
        d_q[p]  <= '0;
      end
    end else if (flush) begin
      wr_q <= '0;
    end else begin
      for (int p = 0; p < NWRPORTS; p++) begin
        wr_q[p] <= p < g_cnt;
        if (p < g_cnt) begin
          wa_q[p] <= g_pr[p];
          d_q[p]  <= g_dat[p];
        end
      end
      if (g_cnt != 0)
        rr <= rr_next;
    end
  end

`ifdef QUPLS_WRARB_STATS_EN
  // Running totals of port writes and deferred conflicting heads.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_writes <= '0;
      stat_defers <= '0;
    end else if (!flush) begin
      stat_writes <= stat_writes + 32'(g_cnt);
      stat_defers <= stat_defers + 32'(defers);
    end
  end
`endif

  assign wr0 = wr_q[0];
  assign wr1 = wr_q[1];
  assign wr2 = wr_q[2];
  assign wr3 = wr_q[3];
  assign we0 = wr_q[0];
  assign we1 = wr_q[1];
  assign we2 = wr_q[2];
  assign we3 = wr_q[3];
  assign wa0 = wa_q[0];
  assign wa1 = wa_q[1];
  assign wa2 = wa_q[2];
  assign wa3 = wa_q[3];
  assign i0  = d_q[0];
  assign i1  = d_q[1];
  assign i2  = d_q[2];
  assign i3  = d_q[3];

endmodule

// File: tb/tb_qupls_regfile_wrarb.sv
// tb/tb_qupls_regfile_wrarb.sv - scoreboard bench for the register-file write arbiter
module tb_qupls_regfile_wrarb;

  typedef struct packed {
    logic [3:0]        wr;
    logic [3:0][8:0]   wa;
    logic [3:0][63:0]  d;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [7:0]       src_v;
  logic [7:0]       src_rdy;
  logic [7:0][8:0]  src_pr;
  logic [7:0][63:0] src_dat;
  logic             wr0, wr1, wr2, wr3, we0, we1, we2, we3;
  logic [8:0]       wa0, wa1, wa2, wa3;
  logic [63:0]      i0, i1, i2, i3;
`ifdef QUPLS_WRARB_STATS_EN
  logic [31:0]      stat_writes;
  logic [31:0]      stat_defers;
  logic [31:0]      sw0, sd0;
`endif

  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];
  exp_t cur = '0;

  logic [3:0]        wrv;
  logic [3:0]        wev;
  logic [3:0][8:0]   wav;
  logic [3:0][63:0]  dv;
  assign wrv = {wr3, wr2, wr1, wr0};
  assign wev = {we3, we2, we1, we0};
  assign wav = {wa3, wa2, wa1, wa0};
  assign dv  = {i3, i2, i1, i0};

  qupls_regfile_wrarb #(.WID(64), .RBIT(8), .NSRC(8), .NPORT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_v(src_v), .src_rdy(src_rdy), .src_pr(src_pr), .src_dat(src_dat),
    .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .we0(we0), .we1(we1), .we2(we2), .we3(we3),
    .wa0(wa0), .wa1(wa1), .wa2(wa2), .wa3(wa3),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3)
`ifdef QUPLS_WRARB_STATS_EN
    , .stat_writes(stat_writes), .stat_defers(stat_defers)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [8:0] pr, input logic [63:0] d);
    src_v[s]   = 1'b1;
    src_pr[s]  = pr;
    src_dat[s] = d;
  endtask

  task automatic clr();
    src_v = '0;
  endtask

  task automatic exp_port(input int p, input logic [8:0] pr, input logic [63:0] d);
    cur.wr[p] = 1'b1;
    cur.wa[p] = pr;
    cur.d[p]  = d;
  endtask

  task automatic exp_push();
    q.push_back(cur);
    cur = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; clr();
    step();
    rst = 1'b0;
  endtask

  // Monitor: every cycle that drives a port must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (wrv != 4'b0) begin
      chk("we_eq_wr", 64'(wev), 64'(wrv));
      if (q.size() == 0) begin
        chk("unexpected_write", 64'(wrv), 64'd0);
      end else begin
        e = q.pop_front();
        chk("port_wr", 64'(wrv), 64'(e.wr));
        for (int p = 0; p < 4; p++)
          if (e.wr[p]) begin
            chk($sformatf("port%0d_wa", p), 64'(wav[p]), 64'(e.wa[p]));
            chk($sformatf("port%0d_i", p), dv[p], e.d[p]);
          end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; src_v = '0; src_pr = '0; src_dat = '0;
    repeat (2) step();
    chk("reset_wr", 64'(wrv), 64'd0);
    chk("reset_wa0", 64'(wa0), 64'd0);
    chk("reset_i0", i0, 64'd0);
    chk("reset_rdy", 64'(src_rdy), 64'hFF);
`ifdef QUPLS_WRARB_STATS_EN
    chk("reset_stats", {stat_writes, stat_defers}, 64'd0);
`endif
    rst = 1'b0;

    // 1: single write, one cycle from accept to port
    set_src(0, 9'h041, 64'hAA);
    step(); clr();
    chk("t1_not_yet", 64'(wrv), 64'd0);
    exp_port(0, 9'h041, 64'hAA); exp_push();
    step();
    chk("t1_wr", 64'(wrv), 64'b0001);
    step();
    chk("t1_one_cycle", 64'(wrv), 64'd0);

    // 2: six sources at once, four then two; rr ends at 6
    do_reset();
    for (int s = 0; s < 6; s++) set_src(s, 9'(9'h010 + s), 64'h100 + 64'(s));
    step(); clr();
    for (int p = 0; p < 4; p++) exp_port(p, 9'(9'h010 + p), 64'h100 + 64'(p));
    exp_push();
    exp_port(0, 9'h014, 64'h104); exp_port(1, 9'h015, 64'h105); exp_push();
    step();
    chk("t2_first", 64'(wrv), 64'b1111);
    step();
    chk("t2_second", 64'(wrv), 64'b0011);
    set_src(6, 9'h026, 64'h606); set_src(0, 9'h020, 64'h600);
    step(); clr();
    exp_port(0, 9'h026, 64'h606); exp_port(1, 9'h020, 64'h600); exp_push();
    step();
    chk("t2_rr6", 64'(wrv), 64'b0011);
    step();

    // 3: same destination from two sources is serialized
    do_reset();
`ifdef QUPLS_WRARB_STATS_EN
    sw0 = stat_writes; sd0 = stat_defers;
`endif
    set_src(2, 9'h055, 64'h22); set_src(3, 9'h055, 64'h33);
    step(); clr();
    exp_port(0, 9'h055, 64'h22); exp_push();
    exp_port(0, 9'h055, 64'h33); exp_push();
    step();
    chk("t3_first", 64'(wrv), 64'b0001);
    step();
    chk("t3_second", 64'(wrv), 64'b0001);
    step();
`ifdef QUPLS_WRARB_STATS_EN
    chk("t3_defers", 64'(stat_defers - sd0), 64'd1);
    chk("t3_writes", 64'(stat_writes - sw0), 64'd2);
`endif

    // 4: r0 alias discarded without taking a port slot
    do_reset();
    set_src(1, 9'h080, 64'hDEAD);
    step(); clr();
    chk("t4_rdy1", 64'(src_rdy[1]), 64'd1);
    step();
    chk("t4_nowrite", 64'(wrv), 64'd0);
    chk("t4_rdy_all", 64'(src_rdy), 64'hFF);
    set_src(1, 9'h080, 64'hBEEF);
    for (int s = 2; s < 6; s++) set_src(s, 9'(9'h040 + s), 64'h200 + 64'(s));
    step(); clr();
    for (int p = 0; p < 4; p++) exp_port(p, 9'(9'h042 + p), 64'h202 + 64'(p));
    exp_push();
    step();
    chk("t4_slot", 64'(wrv), 64'b1111);
    step();

    // 5: source 0 starved until full, then flush; rr survives the flush
    do_reset();
    set_src(0, 9'h001, 64'h1);
    step(); clr();
    exp_port(0, 9'h001, 64'h1); exp_push();
    step(); step();
    set_src(0, 9'h002, 64'h2);
    for (int s = 1; s < 5; s++) set_src(s, 9'(9'h010 + s), 64'h110 + 64'(s));
    step();
    set_src(0, 9'h003, 64'h3);
    for (int s = 1; s < 5; s++) set_src(s, 9'(9'h020 + s), 64'h120 + 64'(s));
    for (int p = 0; p < 4; p++) exp_port(p, 9'(9'h011 + p), 64'h111 + 64'(p));
    exp_push();
    step(); clr();
    chk("t5_others", 64'(wrv), 64'b1111);
    chk("t5_full", 64'(src_rdy), 64'hFE);
    flush = 1'b1;
    set_src(6, 9'h066, 64'h666);
    step(); clr(); flush = 1'b0;
    chk("t5_flush_wr", 64'(wrv), 64'd0);
    chk("t5_flush_rdy", 64'(src_rdy), 64'hFF);
    step(); step();
    set_src(0, 9'h007, 64'h7); set_src(5, 9'h005, 64'h5);
    step(); clr();
    exp_port(0, 9'h005, 64'h5); exp_port(1, 9'h007, 64'h7); exp_push();
    step();
    chk("t5_rr_kept", 64'(wrv), 64'b0011);
    step();

    // 6: reset drops pending results and returns rr to 0
    for (int s = 1; s < 5; s++) set_src(s, 9'(9'h030 + s), 64'h330 + 64'(s));
    step();
    rst = 1'b1;
    set_src(5, 9'h035, 64'h335);
    step(); rst = 1'b0; clr();
    chk("t6_wr", 64'(wrv), 64'd0);
    chk("t6_rdy", 64'(src_rdy), 64'hFF);
    step(); step();
    set_src(7, 9'h077, 64'h777); set_src(0, 9'h070, 64'h700);
    step(); clr();
    exp_port(0, 9'h070, 64'h700); exp_port(1, 9'h077, 64'h777); exp_push();
    step();
    chk("t6_rr0", 64'(wrv), 64'b0011);
    repeat (3) step();

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
